// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage between the PC block and decode.
//
// Issues one word request at a time to instruction memory, queues returned
// instructions with their PCs in a DEPTH-entry FIFO and presents the head to
// decode with a valid/ready handshake. A redirect (flush) empties the queue
// and discards any in-flight response.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   defined   -> adds output fetch_fault; a misaligned pc_in seen in IDLE
//                blocks fetch and raises fetch_fault until flush/reset.
//   undefined -> pc_in[1:0] ignored, addresses forced word-aligned.
//
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   pc_in, pc_en        current PC in, advance/load enable out
//   flush               redirect taken this cycle
//   imem_req/addr/ack   request channel (held until ack)
//   imem_rvalid/rdata   response channel
//   instr_valid/out/pc  queue head to decode, instr_ready consumes it
//   fetch_fault         misaligned-PC trap flag (feature build only)
module fetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [1:0] DROP      = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic        push, pop, issue, misalign, fault;
  logic [31:0] addr_aligned;

  assign addr_aligned = {pc_in[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = pc_in[1:0] != 2'b00;
  assign fetch_fault = fault;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc_in[1:0];
  assign misalign      = 1'b0;
`endif

  // Queue head / handshake
  assign instr_valid = count != '0;
  assign instr_out   = instr_valid ? q_instr[rd_ptr] : NOP_INSTR;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr] : 32'h0;
  assign pop         = instr_valid & instr_ready;
  // A response arriving together with a flush is never queued.
  assign push        = (state == WAIT_DATA) & imem_rvalid & ~flush;
  assign count_after = count + CW'(push) - CW'(pop);

  assign pc_en = (imem_req & imem_ack) | flush;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (~flush & ~misalign & ~fault & (count < CW'(DEPTH))) begin
          state_nxt = WAIT_ACK;
          issue     = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (flush)         state_nxt = imem_ack ? DROP : IDLE;
        else if (imem_ack) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        // Flush with the response in the same cycle: the response is the one
        // we owed, so it is discarded here and nothing is left to drop.
        if (flush) state_nxt = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) begin
          // Back-to-back fetch when room remains; a misaligned PC falls back
          // to IDLE so the trap is taken there.
          if ((count_after < CW'(DEPTH)) & ~misalign) begin
            state_nxt = WAIT_ACK;
            issue     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        // A flush in DROP keeps dropping; only the owed response ends it.
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
    end else begin
      state    <= state_nxt;
      // Request is held until ack; dropped early only by a flush.
      imem_req <= issue | ((state == WAIT_ACK) & ~imem_ack & ~flush);
      if (issue) imem_addr <= addr_aligned;
    end
  end

  always_ff @(posedge clock) begin
    if (reset | flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_after;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clock) begin
    if (push & ~reset) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= imem_addr;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset | flush)                  fault <= 1'b0;
    else if ((state == IDLE) & misalign) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based reference model of the
// fetch stage is stepped every cycle and compared against the DUT outputs.
// Memory and PC block are modelled by the bench environment.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, flush, imem_ack, imem_rvalid, instr_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_en, imem_req, instr_valid;
  logic [31:0] imem_addr, instr_out, instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_en(pc_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what has been requested, what is owed, what is queued.
  bit          m_req, m_infl, m_disc, m_fault;
  logic [31:0] m_addr;
  logic [63:0] m_q[$];

  // Environment: PC block and memory.
  logic [31:0] pc_cur, pc_nxt;
  bit          mem_pend;
  int          mem_dly;

  function automatic logic [31:0] new_target();
    logic [31:0] t;
    t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
    if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  initial begin
    int ready_pct;
    bit pop, mis;
    int cnt0;

    reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; pc_in = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif

    m_req = 0; m_infl = 0; m_disc = 0; m_fault = 0; m_addr = '0; m_q.delete();
    pc_nxt = 32'h0; mem_pend = 0; mem_dly = 0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      pc_cur = pc_nxt;
      // Outputs reflect the previous edge.
      chk("valid", 32'(instr_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("instr", instr_out, m_q[0][31:0]);
        chk("ipc", instr_pc, m_q[0][63:32]);
      end else begin
        chk("instr_nop", instr_out, NOP);
        chk("ipc_empty", instr_pc, 32'h0);
      end
      chk("req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("addr", imem_addr, m_addr);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fault", 32'(fetch_fault), 32'(m_fault));
`endif

      // Drive this cycle's inputs.
      case ((cyc / 750) % 4)
        0: ready_pct = 100;
        1: ready_pct = 50;
        2: ready_pct = 10;
        default: ready_pct = 80;
      endcase
      reset       = cyc > 10 && $urandom_range(0, 299) == 0;
      flush       = $urandom_range(0, 99) < 4;
      instr_ready = $urandom_range(0, 99) < ready_pct;
      imem_ack    = imem_req && $urandom_range(0, 99) < 60;
      imem_rvalid = mem_pend && mem_dly == 0;
      imem_rdata  = $urandom;
      pc_in       = pc_cur;
      #1;
      chk("pc_en", 32'(pc_en), 32'((m_req && imem_ack) || flush));

      // Step the model across the coming edge.
      cnt0 = m_q.size();
      pop  = cnt0 != 0 && instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis = pc_cur[1:0] != 2'b00;
`else
      mis = 1'b0;
`endif
      if (reset) begin
        m_req = 0; m_infl = 0; m_disc = 0; m_fault = 0; m_q.delete();
      end else if (flush) begin
        m_q.delete();
        m_fault = 0;
        if (m_req) begin
          m_req = 0;
          if (imem_ack) begin m_infl = 1; m_disc = 1; end
        end else if (m_infl && imem_rvalid) begin
          m_infl = 0; m_disc = 0;
        end else if (m_infl) begin
          m_disc = 1;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_req) begin
          if (imem_ack) begin m_req = 0; m_infl = 1; end
        end else if (m_infl) begin
          if (imem_rvalid) begin
            m_infl = 0;
            if (m_disc) m_disc = 0;
            else begin
              m_q.push_back({m_addr, imem_rdata});
              if (m_q.size() < DEPTH && !mis) begin
                m_req = 1; m_addr = {pc_cur[31:2], 2'b00};
              end
            end
          end
        end else begin
          if (mis) m_fault = 1;
          else if (cnt0 < DEPTH && !m_fault) begin
            m_req = 1; m_addr = {pc_cur[31:2], 2'b00};
          end
        end
      end

      // Environment next state.
      if (imem_rvalid) mem_pend = 0;
      if (imem_req && imem_ack) begin
        mem_pend = 1; mem_dly = $urandom_range(0, 3);
      end else if (mem_pend && mem_dly > 0) begin
        mem_dly--;
      end
      // A response owed across reset comes back right away and must be ignored.
      if (reset) mem_dly = 0;
      if (reset) pc_nxt = new_target();
      else if (pc_en) pc_nxt = flush ? new_target() : pc_cur + 32'd4;

      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
